// File: rtl/lc3b_types.sv
// Shared types for the LC-3b pipeline control slice.
//   pipe_ctrl_state : stall/flush controller FSM states.
//   lc3b_perf_count : width of the optional performance counters.
//   pipe_ctrl_t     : packed bundle of all barrier enables/bubble strobes,
//                     plus the canonical output patterns the controller emits.
package lc3b_types;

  typedef enum logic {
    RUN         = 1'b0,
    FETCH_DRAIN = 1'b1
  } pipe_ctrl_state;

  typedef logic [15:0] lc3b_perf_count;

  localparam lc3b_perf_count PERF_COUNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic load_pc;
    logic load_if_id;
    logic load_id_ex;
    logic load_ex_mem;
    logic load_mem_wb;
    logic bubble_if_id;
    logic bubble_id_ex;
    logic bubble_ex_mem;
    logic bubble_mem_wb;
    logic pcmux_redirect;
  } pipe_ctrl_t;

  // Bit order: pc, if_id, id_ex, ex_mem, mem_wb | b_if_id, b_id_ex, b_ex_mem, b_mem_wb | pcmux
  localparam pipe_ctrl_t CTRL_RUN      = 10'b11111_0000_0;
  // Everything frozen except MEM/WB, which drains a bubble.
  localparam pipe_ctrl_t CTRL_FREEZE   = 10'b00001_0001_0;
  // Taken redirect: flush three younger stages, MEM/WB keeps the branch (JSR writeback).
  localparam pipe_ctrl_t CTRL_REDIRECT = 10'b11111_1110_1;
  localparam pipe_ctrl_t CTRL_LOAD_USE = 10'b00111_0100_0;
  localparam pipe_ctrl_t CTRL_ISTALL   = 10'b01111_1000_0;

  localparam pipe_ctrl_t CTRL_OFF      = 10'b00000_0000_0;

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Single saturating 16-bit event counter.
//   clk, reset_n : clock, asynchronous active-low reset (zeroes the count)
//   inc          : count one event this cycle
//   clear        : synchronous zero; takes precedence over inc
//   count        : current count, sticks at 0xFFFF
module pipe_ctrl_perf
  import lc3b_types::*;
(
  input  logic           clk,
  input  logic           reset_n,
  input  logic           inc,
  input  logic           clear,
  output lc3b_perf_count count
);

  lc3b_perf_count count_q;
  lc3b_perf_count count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != PERF_COUNT_MAX)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the five-stage LC-3b pipeline.
// Produces same-cycle load enables and bubble strobes for the PC and the
// IF/ID, ID/EX, EX/MEM, MEM/WB barriers, and holds a taken MEM-stage redirect
// until an in-flight I-cache fetch completes.
//   inputs : clk, reset_n (async, active-low), imem_read, imem_resp,
//            dmem_access, dmem_resp, load_use, redirect
//   outputs: load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
//            bubble_if_id, bubble_id_ex, bubble_ex_mem, bubble_mem_wb,
//            pcmux_redirect
// Optional build macro PIPE_CTRL_PERF_EN adds perf_clear and four saturating
// 16-bit counters: perf_imem_stall, perf_dmem_stall, perf_load_use,
// perf_redirect.
module pipe_ctrl
  import lc3b_types::*;
(
  input  logic           clk,
  input  logic           reset_n,
  input  logic           imem_read,
  input  logic           imem_resp,
  input  logic           dmem_access,
  input  logic           dmem_resp,
  input  logic           load_use,
  input  logic           redirect,
  output logic           load_pc,
  output logic           load_if_id,
  output logic           load_id_ex,
  output logic           load_ex_mem,
  output logic           load_mem_wb,
  output logic           bubble_if_id,
  output logic           bubble_id_ex,
  output logic           bubble_ex_mem,
  output logic           bubble_mem_wb,
  output logic           pcmux_redirect
`ifdef PIPE_CTRL_PERF_EN
  ,
  input  logic           perf_clear,
  output lc3b_perf_count perf_imem_stall,
  output lc3b_perf_count perf_dmem_stall,
  output lc3b_perf_count perf_load_use,
  output lc3b_perf_count perf_redirect
`endif
);

  pipe_ctrl_state state_q;
  pipe_ctrl_state state_d;
  pipe_ctrl_t     ctrl;
  pipe_ctrl_t     ctrl_out;
  logic           d_stall;
  logic           i_stall;

  assign d_stall = dmem_access & ~dmem_resp;
  assign i_stall = imem_read & ~imem_resp;

  always_comb begin
    state_d = state_q;
    ctrl    = CTRL_RUN;
    if (d_stall) begin
      // MEM owns the pipe until the D-cache answers; redirect/load_use wait.
      ctrl = CTRL_FREEZE;
    end else if (state_q == FETCH_DRAIN) begin
      // EX/MEM is frozen, so the redirect target is still valid when the fetch lands.
      if (imem_resp) begin
        ctrl    = CTRL_REDIRECT;
        state_d = RUN;
      end else begin
        ctrl = CTRL_FREEZE;
      end
    end else if (redirect) begin
      if (i_stall) begin
        // Never change the fetch address under an outstanding miss.
        ctrl    = CTRL_FREEZE;
        state_d = FETCH_DRAIN;
      end else begin
        ctrl = CTRL_REDIRECT;
      end
    end else if (load_use) begin
      // Beats an I-stall: the ID instruction must stay in IF/ID.
      ctrl = CTRL_LOAD_USE;
    end else if (i_stall) begin
      ctrl = CTRL_ISTALL;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs go quiet the moment reset asserts, independent of the clock.
  assign ctrl_out       = reset_n ? ctrl : CTRL_OFF;
  assign load_pc        = ctrl_out.load_pc;
  assign load_if_id     = ctrl_out.load_if_id;
  assign load_id_ex     = ctrl_out.load_id_ex;
  assign load_ex_mem    = ctrl_out.load_ex_mem;
  assign load_mem_wb    = ctrl_out.load_mem_wb;
  assign bubble_if_id   = ctrl_out.bubble_if_id;
  assign bubble_id_ex   = ctrl_out.bubble_id_ex;
  assign bubble_ex_mem  = ctrl_out.bubble_ex_mem;
  assign bubble_mem_wb  = ctrl_out.bubble_mem_wb;
  assign pcmux_redirect = ctrl_out.pcmux_redirect;

`ifdef PIPE_CTRL_PERF_EN
  logic ev_imem;
  logic ev_dmem;
  logic ev_lu;
  logic ev_redir;

  // Each output pattern is unique except FREEZE, so D-stall is keyed off its condition.
  assign ev_dmem  = d_stall;
  assign ev_imem  = (ctrl == CTRL_ISTALL);
  assign ev_lu    = (ctrl == CTRL_LOAD_USE);
  assign ev_redir = (ctrl == CTRL_REDIRECT);

  pipe_ctrl_perf u_perf_imem (
    .clk(clk), .reset_n(reset_n), .inc(ev_imem), .clear(perf_clear), .count(perf_imem_stall)
  );
  pipe_ctrl_perf u_perf_dmem (
    .clk(clk), .reset_n(reset_n), .inc(ev_dmem), .clear(perf_clear), .count(perf_dmem_stall)
  );
  pipe_ctrl_perf u_perf_lu (
    .clk(clk), .reset_n(reset_n), .inc(ev_lu), .clear(perf_clear), .count(perf_load_use)
  );
  pipe_ctrl_perf u_perf_redir (
    .clk(clk), .reset_n(reset_n), .inc(ev_redir), .clear(perf_clear), .count(perf_redirect)
  );
`else
  // Counters not built; control behaviour is unchanged.
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios followed by randomized cycles,
// each compared against a cycle-level reference model of the controller rules.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic imem_read, imem_resp, dmem_access, dmem_resp, load_use, redirect;
  logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic bubble_if_id, bubble_id_ex, bubble_ex_mem, bubble_mem_wb, pcmux_redirect;
`ifdef PIPE_CTRL_PERF_EN
  logic        perf_clear;
  logic [15:0] perf_imem_stall, perf_dmem_stall, perf_load_use, perf_redirect;
`endif

  pipe_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_access(dmem_access), .dmem_resp(dmem_resp),
    .load_use(load_use), .redirect(redirect),
    .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .bubble_if_id(bubble_if_id), .bubble_id_ex(bubble_id_ex),
    .bubble_ex_mem(bubble_ex_mem), .bubble_mem_wb(bubble_mem_wb),
    .pcmux_redirect(pcmux_redirect)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_clear(perf_clear),
    .perf_imem_stall(perf_imem_stall), .perf_dmem_stall(perf_dmem_stall),
    .perf_load_use(perf_load_use), .perf_redirect(perf_redirect)
`endif
  );

  wire [9:0] obs = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                    bubble_if_id, bubble_id_ex, bubble_ex_mem, bubble_mem_wb,
                    pcmux_redirect};

  // Expected output words: {loads pc..mem_wb, bubbles if_id..mem_wb, pcmux}
  localparam logic [9:0] E_RUN   = 10'b11111_0000_0;
  localparam logic [9:0] E_FRZ   = 10'b00001_0001_0;
  localparam logic [9:0] E_REDIR = 10'b11111_1110_1;
  localparam logic [9:0] E_LU    = 10'b00111_0100_0;
  localparam logic [9:0] E_IST   = 10'b01111_1000_0;

  int checks = 0;
  int passed = 0;

  // Reference model state: a redirect is waiting for the fetch to drain.
  bit pend = 1'b0;
  int unsigned c_im = 0, c_dm = 0, c_lu = 0, c_rd = 0;

  task automatic check_vec(input string tag, input logic [9:0] o, input logic [9:0] e);
    checks++;
    assert (o === e) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, o, e);
  endtask

  task automatic check_cnt(input string tag, input logic [15:0] o, input logic [15:0] e);
    checks++;
    assert (o === e) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, o, e);
  endtask

  // ev: 0 none, 1 dmem stall, 2 imem stall, 3 load-use, 4 completed redirect
  function automatic void model(input bit p, input bit imr, input bit ir, input bit da,
                                input bit dr, input bit lu, input bit rd,
                                output logic [9:0] pat, output bit p_next, output int ev);
    p_next = p;
    ev     = 0;
    if (da && !dr) begin
      pat = E_FRZ; ev = 1;
    end else if (p) begin
      if (ir) begin pat = E_REDIR; p_next = 1'b0; ev = 4; end
      else    pat = E_FRZ;
    end else if (rd && (!imr || ir)) begin
      pat = E_REDIR; ev = 4;
    end else if (rd) begin
      pat = E_FRZ; p_next = 1'b1;
    end else if (lu) begin
      pat = E_LU; ev = 3;
    end else if (imr && !ir) begin
      pat = E_IST; ev = 2;
    end else begin
      pat = E_RUN;
    end
  endfunction

  function automatic int unsigned bump(input int unsigned c, input bit clr, input bit hit);
    if (clr) return 0;
    if (hit && c < 32'hFFFF) return c + 1;
    return c;
  endfunction

  // Called shortly after a rising edge: drive, check before the next edge, advance model.
  task automatic step(input string tag, input bit imr, input bit ir, input bit da,
                      input bit dr, input bit lu, input bit rd, input bit clr);
    logic [9:0] pat;
    bit p_next;
    int ev;
    imem_read = imr; imem_resp = ir; dmem_access = da; dmem_resp = dr;
    load_use = lu; redirect = rd;
`ifdef PIPE_CTRL_PERF_EN
    perf_clear = clr;
`endif
    #2;
    model(pend, imr, ir, da, dr, lu, rd, pat, p_next, ev);
    check_vec(tag, obs, pat);
`ifdef PIPE_CTRL_PERF_EN
    check_cnt({tag, "/perf_im"}, perf_imem_stall, c_im[15:0]);
    check_cnt({tag, "/perf_dm"}, perf_dmem_stall, c_dm[15:0]);
    check_cnt({tag, "/perf_lu"}, perf_load_use,   c_lu[15:0]);
    check_cnt({tag, "/perf_rd"}, perf_redirect,   c_rd[15:0]);
`endif
    @(posedge clk);
    pend = p_next;
    c_dm = bump(c_dm, clr, ev == 1);
    c_im = bump(c_im, clr, ev == 2);
    c_lu = bump(c_lu, clr, ev == 3);
    c_rd = bump(c_rd, clr, ev == 4);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    imem_read = 1'b1; imem_resp = 1'b0; dmem_access = 1'b1; dmem_resp = 1'b0;
    load_use = 1'b1; redirect = 1'b1;
`ifdef PIPE_CTRL_PERF_EN
    perf_clear = 1'b0;
`endif
    #3;
    check_vec("reset_outputs", obs, 10'b0);
    @(posedge clk); @(posedge clk); #1;
    imem_read = 1'b0; dmem_access = 1'b0; load_use = 1'b0; redirect = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Normal flow
    step("normal0", 1, 1, 0, 0, 0, 0, 0);
    step("normal1", 1, 1, 0, 0, 0, 0, 0);
    // D-stall of 3 cycles then response
    for (int i = 0; i < 3; i++) step("dstall", 1, 1, 1, 0, 0, 0, 0);
    step("dstall_resp", 1, 1, 1, 1, 0, 0, 0);
    // Load-use beats I-miss; then plain I-stall
    step("lu_imiss", 1, 0, 0, 0, 1, 0, 0);
    step("istall", 1, 0, 0, 0, 0, 0, 0);
    // Redirect, fetch idle
    step("redir_idle", 0, 0, 0, 0, 1, 1, 0);
    // Redirect, fetch busy, response after 4 cycles
    step("redir_busy", 1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step("drain_hold", 1, 0, 0, 0, 1, 1, 0);
    step("drain_done", 1, 1, 0, 0, 1, 1, 0);
    step("after_drain", 1, 1, 0, 0, 0, 0, 0);
    // Redirect during D-stall
    step("redir_dstall", 0, 0, 1, 0, 0, 1, 0);
    step("redir_dstall", 0, 0, 1, 0, 0, 1, 0);
    step("redir_dresp", 0, 0, 1, 1, 0, 1, 0);
    // Async reset mid-drain
    step("enter_drain", 1, 0, 0, 0, 0, 1, 0);
    step("drain_hold2", 1, 0, 0, 0, 0, 1, 0);
    imem_read = 1'b1; imem_resp = 1'b0; redirect = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    check_vec("async_reset", obs, 10'b0);
    pend = 1'b0; c_im = 0; c_dm = 0; c_lu = 0; c_rd = 0;
`ifdef PIPE_CTRL_PERF_EN
    check_cnt("async_reset/perf_dm", perf_dmem_stall, 16'h0000);
    check_cnt("async_reset/perf_rd", perf_redirect, 16'h0000);
`endif
    imem_read = 1'b0; redirect = 1'b0;
    #3 reset_n = 1'b1;
    step("post_reset_run", 1, 1, 0, 0, 0, 0, 0);

    // Randomized cycles
    for (int i = 0; i < 400; i++) begin
      step("random",
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 31) == 0));
    end

`ifdef PIPE_CTRL_PERF_EN
    // Long D-stall to reach saturation
    step("clear", 1, 1, 0, 0, 0, 0, 1);
    dmem_access = 1'b1; dmem_resp = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    check_cnt("perf_dm_saturate", perf_dmem_stall, 16'hFFFF);
    c_dm = 32'hFFFF;
    step("sat_hold", 1, 1, 1, 0, 0, 0, 0);
    step("sat_clear", 1, 1, 1, 0, 0, 0, 1);
    step("after_clear", 1, 1, 0, 0, 0, 0, 0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

- Central stall/flush controller for the five-stage LC-3b pipeline.
- Generates load enables and bubble-insert strobes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB barriers.
- Inputs: cache handshakes, load-use hazard detect and MEM-stage control-transfer resolution.
- Holds a taken redirect until an in-flight instruction fetch drains, so the I-cache never sees an address change mid-miss.

## Interface
Parameters:
- none

Ports:
- clk  in  1  pipeline clock; one clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- imem_read  in  1  IF stage has a fetch request presented to I-cache.
- imem_resp  in  1  I-cache returns data this cycle.
- dmem_access  in  1  instruction in MEM performs a read or write.
- dmem_resp  in  1  D-cache completes the access this cycle.
- load_use  in  1  ID instruction sources a register loaded by the instruction in EX.
- redirect  in  1  MEM instruction is a taken BR, JMP, JSR or TRAP.
- load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  barrier capture enables.
- bubble_if_id, bubble_id_ex, bubble_ex_mem, bubble_mem_wb  out  1 each  when set with the matching load, the barrier captures an all-zero control word/NOP.
- pcmux_redirect  out  1  PC mux selects the MEM-stage target.

## Operation
- FSM states: RUN, FETCH_DRAIN. Reset state: RUN.
- Outputs are combinational from state and inputs; there is no output register.
- Cases in RUN, listed in priority order:
  - **D-stall** (dmem_access & ~dmem_resp):
    - load_mem_wb=1, bubble_mem_wb=1.
    - All other loads 0.
    - redirect and load_use are ignored.
  - **Redirect, fetch idle** (redirect & (~imem_read | imem_resp)):
    - load_pc=1, pcmux_redirect=1.
    - All four barriers loaded.
    - bubble_if_id, bubble_id_ex and bubble_ex_mem set; MEM/WB takes the branch normally, so JSR writes back.
    - State stays RUN.
  - **Redirect, fetch busy** (redirect & imem_read & ~imem_resp):
    - PC, IF/ID, ID/EX and EX/MEM held.
    - MEM/WB loads a bubble.
    - Next state FETCH_DRAIN.
  - **Load-use**:
    - PC and IF/ID held.
    - ID/EX loads a bubble.
    - EX/MEM and MEM/WB load normally.
    - Overrides an I-stall in the same cycle, because the ID instruction must be kept.
  - **I-stall** (imem_read & ~imem_resp):
    - PC held.
    - IF/ID loads a bubble.
    - Downstream barriers load normally.
  - **Otherwise**: all loads 1, no bubbles.
- FETCH_DRAIN:
  - EX/MEM stays frozen, so the target and the redirect input persist.
  - Until imem_resp: hold pattern as in "Redirect, fetch busy".
  - On imem_resp: perform the "Redirect, fetch idle" pattern; next state RUN.
  - load_use and the fetched instruction are discarded.
- An I-cache response arriving while PC is held is not captured. The frozen PC re-presents the same address, so the re-fetch hits.
- dmem_access is not asserted in FETCH_DRAIN, since MEM holds a completed control transfer. If it is asserted anyway, D-stall takes priority.

## Timing
- With reset_n low: every load_*, bubble_* and pcmux_redirect output is 0, and state is RUN, asynchronously.
- The first cycle after reset release is evaluated normally.
- Zero-latency decisions: the enables apply to the same cycle's clk edge.
- Redirect penalty:
  - Fetch idle: 3 bubbles (IF/ID, ID/EX, EX/MEM).
  - Fetch busy: 3 bubbles plus the N cycles until imem_resp.
- D-stall of N cycles inserts N bubbles into MEM/WB. MEM/WB loads the real instruction on the dmem_resp cycle.
- reset_n asserted in FETCH_DRAIN returns to RUN. The pending redirect is dropped.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - Adds input perf_clear (1 bit, synchronous).
  - Adds four 16-bit outputs: perf_imem_stall, perf_dmem_stall, perf_load_use, perf_redirect.
  - Each counter increments once per cycle in which its condition drives the outputs (perf_redirect counts completed redirects).
  - Counters saturate at 0xFFFF.
  - perf_clear and reset zero all counters; clear wins over increment.
- Undefined: these ports and counters do not exist; control behaviour is identical.

## Structure
- lc3b_types gains:
  - pipe_ctrl_state enum (RUN, FETCH_DRAIN).
  - lc3b_perf_count typedef (16 bits).
- Sub-module pipe_ctrl_perf: one saturating counter with inc/clear, instantiated four times under PIPE_CTRL_PERF_EN.

## Test plan
- **Normal flow:** all inputs quiet, imem_resp every cycle → all loads 1, no bubbles, pcmux_redirect 0.
- **D-stall:** dmem_access=1, dmem_resp low for 3 cycles then high → 3 cycles of only load_mem_wb+bubble_mem_wb; full advance on the resp cycle.
- **Load-use with I-miss:** load_use=1 with imem_read=1, imem_resp=0 → load_pc=0, load_if_id=0, ID/EX bubble, load_ex_mem=load_mem_wb=1.
- **Redirect, fetch busy:** redirect while a fetch misses, imem_resp after 4 cycles → 4 hold cycles in FETCH_DRAIN with MEM/WB bubbles, then load_pc+pcmux_redirect+3 bubbles, state RUN.
- **Redirect during D-stall:** redirect=1, dmem_access=1, dmem_resp=0 → D-stall pattern only; redirect executes on the dmem_resp cycle.
- **Async reset in FETCH_DRAIN:** reset_n low mid-drain → outputs 0 immediately, RUN after release. With PIPE_CTRL_PERF_EN: counters 0; 70000 stall cycles reads 0xFFFF.
